uart_cmd_ctrl: RTL and testbench

Command controller sitting directly downstream of the UART receiver. It consumes received bytes (`P_DATA`/`DATA_Valid`), decodes multi-byte command frames, and drives the register-file and ALU. It returns read and ALU results to the UART transmitter through a one-byte valid/busy handshake. It also owns the ALU clock-gate enable, so the ALU clock runs only while an operation is outstanding.

---
 rtl/uart_cmd_ctrl.sv | 152 +++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART command frame decoder driving register file, ALU, clock gate and TX
module uart_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST_n,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]   RF_RdData,
  input  logic                    RF_RdData_Valid,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_Valid,
  input  logic                    TX_BUSY,
  output logic [ADDR_WIDTH-1:0]   RF_Address,
  output logic                    RF_WrEn,
  output logic                    RF_RdEn,
  output logic [DATA_WIDTH-1:0]   RF_WrData,
  output logic                    ALU_EN,
  output logic [3:0]              ALU_FUN,
  output logic                    Gate_EN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD
);

  localparam logic [DATA_WIDTH-1:0] OP_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OP_ALU_OP = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OP_ALU_NO = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT, S_ALU_OPA,
    S_ALU_OPB, S_ALU_FUN, S_ALU_WAIT, S_TX_B0, S_TX_GAP, S_TX_B1
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_addr_buf;
  logic [2*DATA_WIDTH-1:0] r_tx_buf;
  logic                    r_two_bytes;
  logic [ADDR_WIDTH-1:0]   r_rf_addr;
  logic                    r_wr_en;
  logic                    r_rd_en;
  logic [DATA_WIDTH-1:0]   r_wr_data;
  logic                    r_alu_en;
  logic [3:0]              r_alu_fun;
  logic                    r_gate_en;
  logic [DATA_WIDTH-1:0]   r_tx_data;
  logic                    r_tx_vld;

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      r_state     <= S_IDLE;
      r_addr_buf  <= '0;
      r_tx_buf    <= '0;
      r_two_bytes <= 1'b0;
      r_rf_addr   <= '0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_wr_data   <= '0;
      r_alu_en    <= 1'b0;
      r_alu_fun   <= '0;
      r_gate_en   <= 1'b0;
      r_tx_data   <= '0;
      r_tx_vld    <= 1'b0;
    end else begin
      r_wr_en  <= 1'b0;
      r_rd_en  <= 1'b0;
      r_alu_en <= 1'b0;
      r_tx_vld <= 1'b0;
      case (r_state)
        S_IDLE: if (RX_D_VLD) begin
          case (RX_P_DATA)
            OP_WR:     r_state <= S_WR_ADDR;
            OP_RD:     r_state <= S_RD_ADDR;
            OP_ALU_OP: r_state <= S_ALU_OPA;
            OP_ALU_NO: r_state <= S_ALU_FUN;
            default:   r_state <= S_IDLE;
          endcase
        end
        S_WR_ADDR: if (RX_D_VLD) begin
          r_addr_buf <= RX_P_DATA[ADDR_WIDTH-1:0];
          r_state    <= S_WR_DATA;
        end
        S_WR_DATA: if (RX_D_VLD) begin
          r_rf_addr <= r_addr_buf;
          r_wr_data <= RX_P_DATA;
          r_wr_en   <= 1'b1;
          r_state   <= S_IDLE;
        end
        S_RD_ADDR: if (RX_D_VLD) begin
          r_rf_addr <= RX_P_DATA[ADDR_WIDTH-1:0];
          r_rd_en   <= 1'b1;
          r_state   <= S_RD_WAIT;
        end
        S_RD_WAIT: if (RF_RdData_Valid) begin
          r_tx_buf    <= {{DATA_WIDTH{1'b0}}, RF_RdData};
          r_two_bytes <= 1'b0;
          r_state     <= S_TX_B0;
        end
        // Operands land in fixed RF slots 0/1 where the ALU reads them.
        S_ALU_OPA: if (RX_D_VLD) begin
          r_rf_addr <= ADDR_WIDTH'(0);
          r_wr_data <= RX_P_DATA;
          r_wr_en   <= 1'b1;
          r_state   <= S_ALU_OPB;
        end
        S_ALU_OPB: if (RX_D_VLD) begin
          r_rf_addr <= ADDR_WIDTH'(1);
          r_wr_data <= RX_P_DATA;
          r_wr_en   <= 1'b1;
          r_state   <= S_ALU_FUN;
        end
        S_ALU_FUN: if (RX_D_VLD) begin
          r_alu_fun <= RX_P_DATA[3:0];
          r_alu_en  <= 1'b1;
          r_gate_en <= 1'b1;
          r_state   <= S_ALU_WAIT;
        end
        S_ALU_WAIT: if (ALU_OUT_Valid) begin
          r_tx_buf    <= ALU_OUT;
          r_two_bytes <= 1'b1;
          r_gate_en   <= 1'b0;
          r_state     <= S_TX_B0;
        end
        S_TX_B0: if (!TX_BUSY) begin
          r_tx_data <= r_tx_buf[DATA_WIDTH-1:0];
          r_tx_vld  <= 1'b1;
          r_state   <= r_two_bytes ? S_TX_GAP : S_IDLE;
        end
        // Wait for TX to acknowledge the low byte before offering the high one.
        S_TX_GAP: if (TX_BUSY) r_state <= S_TX_B1;
        S_TX_B1: if (!TX_BUSY) begin
          r_tx_data <= r_tx_buf[2*DATA_WIDTH-1:DATA_WIDTH];
          r_tx_vld  <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign RF_Address = r_rf_addr;
  assign RF_WrEn    = r_wr_en;
  assign RF_RdEn    = r_rd_en;
  assign RF_WrData  = r_wr_data;
  assign ALU_EN     = r_alu_en;
  assign ALU_FUN    = r_alu_fun;
  assign Gate_EN    = r_gate_en;
  assign TX_P_DATA  = r_tx_data;
  assign TX_D_VLD   = r_tx_vld;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - self-checking bench for uart_cmd_ctrl with frame-level reference model
module tb_uart_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [7:0]  RF_RdData;
  logic        RF_RdData_Valid;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_Valid;
  logic        TX_BUSY;
  logic [3:0]  RF_Address;
  logic        RF_WrEn;
  logic        RF_RdEn;
  logic [7:0]  RF_WrData;
  logic        ALU_EN;
  logic [3:0]  ALU_FUN;
  logic        Gate_EN;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] mem [16];

  uart_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .CLK(CLK), .RST_n(RST_n),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_RdData(RF_RdData), .RF_RdData_Valid(RF_RdData_Valid),
    .ALU_OUT(ALU_OUT), .ALU_OUT_Valid(ALU_OUT_Valid),
    .TX_BUSY(TX_BUSY),
    .RF_Address(RF_Address), .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn),
    .RF_WrData(RF_WrData), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
    .Gate_EN(Gate_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge CLK);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(posedge CLK); #1;
    RX_D_VLD  = 1'b0;
    RX_P_DATA = 8'($urandom);
  endtask

  task automatic check_quiet(input string tag);
    check(tag, {RF_WrEn, RF_RdEn, ALU_EN, TX_D_VLD}, 4'b0000);
  endtask

  function automatic logic [15:0] alu_model(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      4'd3:    return {a, b};
      default: return {b, a ^ b};
    endcase
  endfunction

  task automatic do_write(input logic [7:0] ab, input logic [7:0] db);
    send(8'hAA);
    check_quiet("wr_op_quiet");
    send(ab);
    check_quiet("wr_addr_quiet");
    send(db);
    check("wr_strobe", {RF_WrEn, RF_Address, RF_WrData, TX_D_VLD}, {1'b1, ab[3:0], db, 1'b0});
    tick();
    check("wr_hold", {RF_WrEn, RF_Address, RF_WrData}, {1'b0, ab[3:0], db});
    mem[ab[3:0]] = db;
  endtask

  task automatic do_read(input logic [7:0] ab, input int njunk);
    logic [7:0] exp_d;
    exp_d = mem[ab[3:0]];
    send(8'hBB);
    check_quiet("rd_op_quiet");
    send(ab);
    check("rd_strobe", {RF_RdEn, RF_Address, RF_WrEn}, {1'b1, ab[3:0], 1'b0});
    tick();
    check("rd_one_cycle", {RF_RdEn, TX_D_VLD}, 2'b00);
    for (int i = 0; i < njunk; i++) begin
      send(8'($urandom));
      check_quiet("rd_wait_junk");
    end
    @(negedge CLK);
    RF_RdData       = exp_d;
    RF_RdData_Valid = 1'b1;
    @(posedge CLK); #1;
    RF_RdData_Valid = 1'b0;
    RF_RdData       = ~exp_d;
    check("rd_capture_no_tx", TX_D_VLD, 1'b0);
    tick();
    check("rd_tx", {TX_D_VLD, TX_P_DATA}, {1'b1, exp_d});
    tick();
    check("rd_tx_hold", {TX_D_VLD, TX_P_DATA}, {1'b0, exp_d});
  endtask

  task automatic do_alu(input bit with_ops, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] fun, input logic [15:0] res,
                        input bit busy_at_res, input int pre_gap, input int gap);
    if (with_ops) begin
      send(8'hCC);
      check_quiet("alu_op_quiet");
      send(a);
      check("alu_opa_wr", {RF_WrEn, RF_Address, RF_WrData}, {1'b1, 4'd0, a});
      send(b);
      check("alu_opb_wr", {RF_WrEn, RF_Address, RF_WrData}, {1'b1, 4'd1, b});
      mem[0] = a;
      mem[1] = b;
    end else begin
      send(8'hDD);
      check_quiet("alu_no_op_quiet");
    end
    send(fun);
    check("alu_start", {ALU_EN, ALU_FUN, Gate_EN, RF_WrEn}, {1'b1, fun[3:0], 1'b1, 1'b0});
    tick();
    check("alu_en_one_cycle", {ALU_EN, Gate_EN}, 2'b01);
    repeat ($urandom_range(0, 3)) begin
      tick();
      check("alu_gate_held", {Gate_EN, TX_D_VLD}, 2'b10);
    end
    @(negedge CLK);
    ALU_OUT       = res;
    ALU_OUT_Valid = 1'b1;
    TX_BUSY       = busy_at_res;
    @(posedge CLK); #1;
    ALU_OUT_Valid = 1'b0;
    ALU_OUT       = ~res;
    check("alu_gate_drop", {Gate_EN, TX_D_VLD, ALU_FUN}, {1'b0, 1'b0, fun[3:0]});
    if (busy_at_res) begin
      repeat (3) begin
        tick();
        check("alu_tx_withheld", TX_D_VLD, 1'b0);
      end
      @(negedge CLK);
      TX_BUSY = 1'b0;
    end
    tick();
    check("alu_tx_lo", {TX_D_VLD, TX_P_DATA}, {1'b1, res[7:0]});
    for (int i = 0; i < pre_gap; i++) begin
      tick();
      check("alu_gap_wait_busy", TX_D_VLD, 1'b0);
    end
    @(negedge CLK);
    TX_BUSY = 1'b1;
    for (int i = 0; i < gap; i++) begin
      tick();
      check("alu_gap_busy", {TX_D_VLD, TX_P_DATA}, {1'b0, res[7:0]});
    end
    @(negedge CLK);
    TX_BUSY = 1'b0;
    tick();
    check("alu_tx_hi", {TX_D_VLD, TX_P_DATA}, {1'b1, res[15:8]});
    tick();
    check("alu_tx_hi_hold", {TX_D_VLD, TX_P_DATA}, {1'b0, res[15:8]});
  endtask

  initial begin
    logic [7:0] b0, b1, b2;
    RST_n = 1'b0; RX_P_DATA = '0; RX_D_VLD = 1'b0; RF_RdData = '0; RF_RdData_Valid = 1'b0;
    ALU_OUT = '0; ALU_OUT_Valid = 1'b0; TX_BUSY = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    tick(); tick();
    check("reset_outputs", {RF_Address, RF_WrEn, RF_RdEn, RF_WrData, ALU_EN, ALU_FUN, Gate_EN, TX_P_DATA, TX_D_VLD}, 32'd0);
    @(negedge CLK); RST_n = 1'b1;

    do_write(8'h05, 8'h3C);
    check("write_reg5_model", mem[5], 8'h3C);
    mem[3] = 8'h7E;
    do_read(8'h13, 0);
    do_read(8'h13, 2);
    do_alu(1'b1, 8'h0A, 8'h03, 8'h02, 16'h1234, 1'b0, 0, 10);

    send(8'h55);
    check_quiet("ignored_55");
    tick();
    check_quiet("ignored_55_after");
    do_write(8'hF9, 8'hA5);

    send(8'hAA);
    send(8'h05);
    @(negedge CLK); RST_n = 1'b0;
    tick(); tick();
    check("reset_mid_frame", {RF_Address, RF_WrEn, RF_RdEn, RF_WrData, ALU_EN, ALU_FUN, Gate_EN, TX_P_DATA, TX_D_VLD}, 32'd0);
    @(negedge CLK); RST_n = 1'b1;
    send(8'h3C);
    check_quiet("after_reset_3c");
    tick();
    check("after_reset_3c_wr", {RF_WrEn, RF_Address, RF_WrData}, 13'd0);
    do_write(8'h02, 8'h11);

    do_alu(1'b0, 8'h00, 8'h00, 8'hF1, alu_model(4'h1, mem[0], mem[1]), 1'b1, 1, 2);

    send(8'hDD);
    send(8'h04);
    tick();
    @(negedge CLK); RST_n = 1'b0;
    tick();
    check("reset_clears_gate", {Gate_EN, ALU_FUN}, 5'd0);
    @(negedge CLK); RST_n = 1'b1;
    do_read(8'h02, 1);

    for (int it = 0; it < 24; it++) begin
      b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
      case ($urandom_range(0, 4))
        0: do_write(b0, b1);
        1: do_read(b0, $urandom_range(0, 2));
        2: do_alu(1'b1, b0, b1, b2, alu_model(b2[3:0], b0, b1),
                  1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(1, 4));
        3: do_alu(1'b0, 8'h00, 8'h00, b2, alu_model(b2[3:0], mem[0], mem[1]),
                  1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(1, 4));
        default: begin
          if (b0 != 8'hAA && b0 != 8'hBB && b0 != 8'hCC && b0 != 8'hDD) begin
            send(b0);
            check_quiet("rand_ignored");
          end
        end
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
